wb_ram: RTL and testbench

WB_RAM -- requirements
Module: wb_ram

---
 rtl/wb_ram.sv | 122 ++++++++++++
 tb/tb_wb_ram.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram.sv
// rtl/wb_ram.sv - Wishbone-style 32-bit word RAM with byte lanes and wait states
// Optional address range checking is enabled by defining WB_RAM_RANGE_CHECK_EN.
module wb_ram #(
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_wb_addr,
    input  logic        i_wb_cyc,
    input  logic [3:0]  i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

    state_t                 state;
    logic [3:0]             wait_cnt;
    logic [ADDR_BITS-1:0]   idx_q;
    logic                   we_q;
    logic [3:0]             stb_q;
    logic [31:0]            dat_q;
    logic                   range_err_q;
    logic [31:0]            mem [DEPTH];

    logic [31:0] offset;
    logic        request;
    logic        out_of_range;
    logic [31:0] lane_mask;
    logic        mem_we;
    logic        unused_addr_bits;

    assign offset  = i_wb_addr - BASE_ADDR;
    assign request = i_wb_cyc && (i_wb_stb != 4'b0000);

`ifdef WB_RAM_RANGE_CHECK_EN
    assign out_of_range = |offset[31:ADDR_BITS+2];
`else
    assign out_of_range = 1'b0;
`endif

    assign unused_addr_bits = ^{offset[1:0], offset[31:ADDR_BITS+2]};

    // stb[3] selects the lowest byte address, which is the most significant byte.
    assign lane_mask = {{8{stb_q[3]}}, {8{stb_q[2]}}, {8{stb_q[1]}}, {8{stb_q[0]}}};

    // Gating with i_reset keeps a write from committing on an edge during reset.
    assign mem_we = (state == RESP) && we_q && !range_err_q && i_reset;

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (stb_q[b]) begin
                    mem[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            idx_q       <= '0;
            we_q        <= 1'b0;
            stb_q       <= 4'b0000;
            dat_q       <= 32'h0;
            range_err_q <= 1'b0;
            o_wb_dat    <= 32'h0;
            o_wb_ack    <= 1'b0;
            o_wb_err    <= 1'b0;
        end else begin
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= 32'h0;
            case (state)
                IDLE: begin
                    if (request) begin
                        idx_q       <= offset[ADDR_BITS+1:2];
                        we_q        <= i_wb_we;
                        stb_q       <= i_wb_stb;
                        dat_q       <= i_wb_dat;
                        range_err_q <= out_of_range;
                        wait_cnt    <= 4'd0;
                        state       <= (WAIT_STATES > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (!i_wb_cyc) begin
                        state <= IDLE;
                    end else if (wait_cnt == 4'(WAIT_STATES - 1)) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (range_err_q) begin
                        o_wb_err <= 1'b1;
                    end else begin
                        o_wb_ack <= 1'b1;
                        o_wb_dat <= mem[idx_q] & lane_mask;
                    end
                    wait_cnt <= 4'd0;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_ram.sv
// tb/tb_wb_ram.sv - directed testbench for wb_ram (three instances: 0, 2 and 3 wait states)
module tb_wb_ram;
    localparam logic [31:0] B0 = 32'h0001_0000;
    localparam logic [31:0] B2 = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  stb;
    logic        we;
    logic        cyc0, cyc2, cyc3;
    logic [31:0] dat0, dat2, dat3;
    logic        ack0, ack2, ack3;
    logic        err0, err2, err3;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    wb_ram #(.ADDR_BITS(10), .WAIT_STATES(0), .BASE_ADDR(B0)) dut0 (
        .i_clk(clk), .i_reset(rst_n), .i_wb_addr(addr), .i_wb_cyc(cyc0), .i_wb_stb(stb),
        .i_wb_we(we), .i_wb_dat(wdat), .o_wb_dat(dat0), .o_wb_ack(ack0), .o_wb_err(err0));

    wb_ram #(.ADDR_BITS(6), .WAIT_STATES(2), .BASE_ADDR(B2)) dut2 (
        .i_clk(clk), .i_reset(rst_n), .i_wb_addr(addr), .i_wb_cyc(cyc2), .i_wb_stb(stb),
        .i_wb_we(we), .i_wb_dat(wdat), .o_wb_dat(dat2), .o_wb_ack(ack2), .o_wb_err(err2));

    wb_ram #(.ADDR_BITS(10), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut3 (
        .i_clk(clk), .i_reset(rst_n), .i_wb_addr(addr), .i_wb_cyc(cyc3), .i_wb_stb(stb),
        .i_wb_we(we), .i_wb_dat(wdat), .o_wb_dat(dat3), .o_wb_ack(ack3), .o_wb_err(err3));

    task automatic set_cyc(input int d, input logic v);
        case (d)
            0: cyc0 = v;
            2: cyc2 = v;
            default: cyc3 = v;
        endcase
    endtask

    task automatic sel(input int d, output logic a, output logic e, output logic [31:0] q);
        case (d)
            0: begin a = ack0; e = err0; q = dat0; end
            2: begin a = ack2; e = err2; q = dat2; end
            default: begin a = ack3; e = err3; q = dat3; end
        endcase
    endtask

    // Drives one request; lat is the number of edges after the request edge until ack/err (-1 = none).
    task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [3:0] s,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat,
                        output logic got_ack, output logic got_err);
        logic        a_, e_;
        logic [31:0] q_;
        @(posedge clk); #1;
        addr = a; we = w; stb = s; wdat = wd;
        set_cyc(d, 1'b1);
        @(posedge clk);
        lat = -1; rd = 32'h0; got_ack = 1'b0; got_err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #2;
            sel(d, a_, e_, q_);
            if (a_ || e_) begin
                lat = k; rd = q_; got_ack = a_; got_err = e_;
                break;
            end
        end
        set_cyc(d, 1'b0);
        stb = 4'b0000; we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cyc0 = 1'b0; cyc2 = 1'b0; cyc3 = 1'b0;
        addr = 32'h0; wdat = 32'h0; stb = 4'b0000; we = 1'b0;
        #3;
        checks++;
        if ({ack0, err0, dat0} !== 34'h0) begin
            errors++; $display("FAIL reset_dut0: got ack=%b err=%b dat=%h, want 0/0/0", ack0, err0, dat0);
        end
        checks++;
        if ({ack2, err2, dat2} !== 34'h0) begin
            errors++; $display("FAIL reset_dut2: got ack=%b err=%b dat=%h, want 0/0/0", ack2, err2, dat2);
        end
        checks++;
        if ({ack3, err3, dat3} !== 34'h0) begin
            errors++; $display("FAIL reset_dut3: got ack=%b err=%b dat=%h, want 0/0/0", ack3, err3, dat3);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_stb_zero();
        logic seen = 1'b0;
        @(posedge clk); #1;
        addr = B0 + 32'h10; we = 1'b0; stb = 4'b0000; cyc0 = 1'b1;
        repeat (4) begin
            @(posedge clk); #2;
            if (ack0 || err0) seen = 1'b1;
        end
        cyc0 = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL stb_zero_ignored: got response=%b, want 0", seen);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        int          lat;
        logic        ga, ge;
        xfer(0, B0 + 32'h10, 1'b1, 4'b1111, 32'hDEADBEEF, rd, lat, ga, ge);
        checks++;
        if (lat !== 1 || ga !== 1'b1 || ge !== 1'b0) begin
            errors++; $display("FAIL write_latency: got lat=%0d ack=%b err=%b, want 1/1/0", lat, ga, ge);
        end
        xfer(0, B0 + 32'h10, 1'b0, 4'b1111, 32'h0, rd, lat, ga, ge);
        checks++;
        if (lat !== 1 || rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL read_word: got lat=%0d dat=%h, want 1/deadbeef", lat, rd);
        end
        @(posedge clk); #2;
        checks++;
        if (ack0 !== 1'b0 || dat0 !== 32'h0) begin
            errors++; $display("FAIL ack_one_cycle: got ack=%b dat=%h, want 0/00000000", ack0, dat0);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        int          lat;
        logic        ga, ge;
        xfer(0, B0 + 32'h12, 1'b0, 4'b0011, 32'h0, rd, lat, ga, ge);
        checks++;
        if (rd !== 32'h0000BEEF) begin
            errors++; $display("FAIL read_halfword: got %h, want 0000beef", rd);
        end
        xfer(0, B0 + 32'h10, 1'b1, 4'b0100, 32'h00AA0000, rd, lat, ga, ge);
        checks++;
        if (rd !== 32'h00AD0000) begin
            errors++; $display("FAIL write_read_first: got %h, want 00ad0000", rd);
        end
        xfer(0, B0 + 32'h10, 1'b0, 4'b1111, 32'h0, rd, lat, ga, ge);
        checks++;
        if (rd !== 32'hDEAABEEF) begin
            errors++; $display("FAIL byte_write: got %h, want deaabeef", rd);
        end
        xfer(0, B0 + 32'h20, 1'b1, 4'b1111, 32'h11223344, rd, lat, ga, ge);
        xfer(0, B0 + 32'h20, 1'b1, 4'b1001, 32'hA5A5A5A5, rd, lat, ga, ge);
        xfer(0, B0 + 32'h20, 1'b0, 4'b1111, 32'h0, rd, lat, ga, ge);
        checks++;
        if (rd !== 32'hA52233A5) begin
            errors++; $display("FAIL outer_lanes_write: got %h, want a52233a5", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pattern = 4'b0000;
        logic       both = 1'b0;
        @(posedge clk); #1;
        addr = B0 + 32'h20; we = 1'b0; stb = 4'b1111; cyc0 = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            pattern[k] = ack0;
            if (ack0 && err0) both = 1'b1;
        end
        cyc0 = 1'b0; stb = 4'b0000;
        checks++;
        if (pattern !== 4'b1001 || both !== 1'b0) begin
            errors++; $display("FAIL no_back_to_back: got ack pattern=%b both=%b, want 1001/0", pattern, both);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        int          lat;
        logic        ga, ge;
        xfer(3, 32'h40, 1'b1, 4'b1111, 32'hCAFEF00D, rd, lat, ga, ge);
        checks++;
        if (lat !== 4 || ga !== 1'b1) begin
            errors++; $display("FAIL ws3_write_latency: got lat=%0d ack=%b, want 4/1", lat, ga);
        end
        xfer(3, 32'h40, 1'b0, 4'b1111, 32'h0, rd, lat, ga, ge);
        checks++;
        if (lat !== 4 || rd !== 32'hCAFEF00D) begin
            errors++; $display("FAIL ws3_read: got lat=%0d dat=%h, want 4/cafef00d", lat, rd);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int          lat;
        logic        ga, ge;
        logic        seen = 1'b0;
        @(posedge clk); #1;
        addr = 32'h40; we = 1'b1; stb = 4'b1111; wdat = 32'h11111111; cyc3 = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 cyc3 = 1'b0;
        repeat (4) begin
            @(posedge clk); #2;
            if (ack3 || err3) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL abort_no_response: got response=%b, want 0", seen);
        end
        xfer(3, 32'h40, 1'b0, 4'b1111, 32'h0, rd, lat, ga, ge);
        checks++;
        if (lat !== 4 || rd !== 32'hCAFEF00D) begin
            errors++; $display("FAIL abort_no_write: got lat=%0d dat=%h, want 4/cafef00d", lat, rd);
        end
    endtask

    task automatic test_range();
        logic [31:0] rd;
        int          lat;
        logic        ga, ge;
        xfer(3, 32'h0, 1'b1, 4'b1111, 32'h0BADC0DE, rd, lat, ga, ge);
        xfer(3, 32'h1000, 1'b0, 4'b1111, 32'h0, rd, lat, ga, ge);
`ifdef WB_RAM_RANGE_CHECK_EN
        checks++;
        if (ge !== 1'b1 || ga !== 1'b0 || rd !== 32'h0 || lat !== 4) begin
            errors++; $display("FAIL range_err: got err=%b ack=%b dat=%h lat=%0d, want 1/0/0/4", ge, ga, rd, lat);
        end
        @(posedge clk); #2;
        checks++;
        if (err3 !== 1'b0) begin
            errors++; $display("FAIL range_err_pulse: got err=%b, want 0", err3);
        end
        xfer(3, 32'h1000, 1'b1, 4'b1111, 32'hFFFFFFFF, rd, lat, ga, ge);
        xfer(3, 32'h0, 1'b0, 4'b1111, 32'h0, rd, lat, ga, ge);
        checks++;
        if (rd !== 32'h0BADC0DE) begin
            errors++; $display("FAIL range_no_write: got %h, want 0badc0de", rd);
        end
`else
        checks++;
        if (ga !== 1'b1 || ge !== 1'b0 || rd !== 32'h0BADC0DE) begin
            errors++; $display("FAIL range_wrap: got ack=%b err=%b dat=%h, want 1/0/0badc0de", ga, ge, rd);
        end
`endif
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        int          lat;
        logic        ga, ge;
        logic        seen = 1'b0;
        xfer(2, B2 + 32'h8, 1'b1, 4'b1111, 32'h55AA55AA, rd, lat, ga, ge);
        checks++;
        if (lat !== 3 || ga !== 1'b1) begin
            errors++; $display("FAIL ws2_write_latency: got lat=%0d ack=%b, want 3/1", lat, ga);
        end
        @(posedge clk); #1;
        addr = B2 + 32'h8; we = 1'b1; stb = 4'b1111; wdat = 32'hFFFFFFFF; cyc2 = 1'b1;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack2, err2, dat2} !== 34'h0) begin
            errors++; $display("FAIL reset_mid_wait_outputs: got ack=%b err=%b dat=%h, want 0", ack2, err2, dat2);
        end
        repeat (2) begin
            @(posedge clk); #2;
            if (ack2 || err2) seen = 1'b1;
        end
        cyc2 = 1'b0; stb = 4'b0000; we = 1'b0;
        rst_n = 1'b1;
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL reset_mid_wait_no_ack: got response=%b, want 0", seen);
        end
        xfer(2, B2 + 32'h8, 1'b0, 4'b1111, 32'h0, rd, lat, ga, ge);
        checks++;
        if (lat !== 3 || rd !== 32'h55AA55AA) begin
            errors++; $display("FAIL reset_no_commit: got lat=%0d dat=%h, want 3/55aa55aa", lat, rd);
        end
        // Async reset must clear an ack that is already on the bus.
        @(posedge clk); #1;
        addr = B0 + 32'h10; we = 1'b0; stb = 4'b1111; cyc0 = 1'b1;
        @(posedge clk);
        @(posedge clk); #2;
        checks++;
        if (ack0 !== 1'b1 || dat0 !== 32'hDEAABEEF) begin
            errors++; $display("FAIL pre_reset_ack: got ack=%b dat=%h, want 1/deaabeef", ack0, dat0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ack0 !== 1'b0 || dat0 !== 32'h0) begin
            errors++; $display("FAIL async_reset_ack: got ack=%b dat=%h, want 0/00000000", ack0, dat0);
        end
        cyc0 = 1'b0; stb = 4'b0000;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stb_zero();
        test_write_read();
        test_byte_lanes();
        test_back_to_back();
        test_wait_states();
        test_abort();
        test_range();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
